// File: rtl/mem_req_initiator.sv
// Memory request initiator: issues tagged read/write requests and
// retires responses into a single completion register.
module mem_req_initiator #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_OUTSTANDING = 8,
   localparam int ID_WIDTH       = $clog2(MAX_OUTSTANDING),
   localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wrn,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [STRB_WIDTH-1:0] cmd_strb,

   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_wrn,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [ID_WIDTH-1:0]   req_id,
   output logic [DATA_WIDTH-1:0] req_data,
   output logic [STRB_WIDTH-1:0] req_strb,

   input  logic                  wr_res_valid,
   output logic                  wr_res_ready,
   input  logic [ID_WIDTH-1:0]   wr_res_id,
   input  logic                  wr_res_err,

   input  logic                  rd_res_valid,
   output logic                  rd_res_ready,
   input  logic [ID_WIDTH-1:0]   rd_res_id,
   input  logic [DATA_WIDTH-1:0] rd_res_data,
   input  logic                  rd_res_err,

   output logic                  cpl_valid,
   input  logic                  cpl_ready,
   output logic                  cpl_wrn,
   output logic [ID_WIDTH-1:0]   cpl_id,
   output logic [DATA_WIDTH-1:0] cpl_data,
   output logic                  cpl_err,

   output logic [ID_WIDTH:0]     outstanding_cnt,
   output logic                  protocol_err
);

   localparam logic [ID_WIDTH:0] CNT_ONE = (ID_WIDTH+1)'(1);

   logic [MAX_OUTSTANDING-1:0] trk_valid;
   logic [MAX_OUTSTANDING-1:0] trk_wrn;

   logic [ID_WIDTH-1:0]   alloc_id;
   logic                  free_any;
   logic                  cmd_fire;
   logic                  cpl_space;
   logic                  rd_turn;
   logic                  rd_grant;
   logic                  wr_grant;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  rsp_fire;
   logic                  rsp_wrn;
   logic [ID_WIDTH-1:0]   rsp_id;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_ok;
   logic                  rsp_free;

   // Lowest-index free entry wins; scan from the top so index 0 lands last.
   always_comb begin
      alloc_id = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
         if (!trk_valid[i]) alloc_id = ID_WIDTH'(i);
      end
   end

   assign free_any  = ~&trk_valid;
   assign cmd_ready = ~rst & free_any & (~req_valid | req_ready);
   assign cmd_fire  = cmd_valid & cmd_ready;

   assign cpl_space    = ~cpl_valid | cpl_ready;
   assign rd_grant     = rd_res_valid & (~wr_res_valid | rd_turn);
   assign wr_grant     = wr_res_valid & (~rd_res_valid | ~rd_turn);
   assign rd_res_ready = ~rst & rd_grant & cpl_space;
   assign wr_res_ready = ~rst & wr_grant & cpl_space;
   assign rd_fire      = rd_res_valid & rd_res_ready;
   assign wr_fire      = wr_res_valid & wr_res_ready;
   assign rsp_fire     = rd_fire | wr_fire;

   assign rsp_wrn  = rd_fire;
   assign rsp_id   = rd_fire ? rd_res_id : wr_res_id;
   assign rsp_err  = rd_fire ? rd_res_err : wr_res_err;
   assign rsp_data = rd_fire ? rd_res_data : '0;

   // A response must match a live entry of the same direction to retire it.
   assign rsp_ok   = trk_valid[rsp_id] & (trk_wrn[rsp_id] == rsp_wrn);
   assign rsp_free = rsp_fire & rsp_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid <= 1'b0;
         req_wrn   <= 1'b0;
         req_addr  <= '0;
         req_id    <= '0;
         req_data  <= '0;
         req_strb  <= '0;
      end else if (cmd_fire) begin
         req_valid <= 1'b1;
         req_wrn   <= cmd_wrn;
         req_addr  <= cmd_addr;
         req_id    <= alloc_id;
         req_data  <= cmd_data;
         req_strb  <= cmd_strb;
      end else if (req_ready) begin
         req_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trk_valid <= '0;
         trk_wrn   <= '0;
      end else begin
         if (rsp_free) trk_valid[rsp_id] <= 1'b0;
         if (cmd_fire) begin
            trk_valid[alloc_id] <= 1'b1;
            trk_wrn[alloc_id]   <= cmd_wrn;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_cnt <= '0;
      end else begin
         unique case ({cmd_fire, rsp_free})
            2'b10:   outstanding_cnt <= outstanding_cnt + CNT_ONE;
            2'b01:   outstanding_cnt <= outstanding_cnt - CNT_ONE;
            default: outstanding_cnt <= outstanding_cnt;
         endcase
      end
   end

   // Turn only flips when both sides contend, so a lone requester never
   // steals the other's next slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_turn <= 1'b1;
      end else if (rd_fire && wr_res_valid) begin
         rd_turn <= 1'b0;
      end else if (wr_fire && rd_res_valid) begin
         rd_turn <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpl_valid <= 1'b0;
         cpl_wrn   <= 1'b0;
         cpl_id    <= '0;
         cpl_data  <= '0;
         cpl_err   <= 1'b0;
      end else if (rsp_fire) begin
         cpl_valid <= 1'b1;
         cpl_wrn   <= rsp_wrn;
         cpl_id    <= rsp_id;
         cpl_data  <= rsp_data;
         cpl_err   <= rsp_err | ~rsp_ok;
      end else if (cpl_ready) begin
         cpl_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         protocol_err <= 1'b0;
      end else if (rsp_fire && !rsp_ok) begin
         protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Randomized and directed bench for mem_req_initiator against a
// transaction-level reference model.
module tb_mem_req_initiator;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int N  = 8;
   localparam int IW = 3;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_wrn;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [SW-1:0] cmd_strb;
   logic          req_valid, req_ready, req_wrn;
   logic [AW-1:0] req_addr;
   logic [IW-1:0] req_id;
   logic [DW-1:0] req_data;
   logic [SW-1:0] req_strb;
   logic          wr_res_valid, wr_res_ready, wr_res_err;
   logic [IW-1:0] wr_res_id;
   logic          rd_res_valid, rd_res_ready, rd_res_err;
   logic [IW-1:0] rd_res_id;
   logic [DW-1:0] rd_res_data;
   logic          cpl_valid, cpl_ready, cpl_wrn, cpl_err;
   logic [IW-1:0] cpl_id;
   logic [DW-1:0] cpl_data;
   logic [IW:0]   outstanding_cnt;
   logic          protocol_err;

   always #5 clk = ~clk;

   mem_req_initiator dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wrn(cmd_wrn),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .req_valid(req_valid), .req_ready(req_ready), .req_wrn(req_wrn),
      .req_addr(req_addr), .req_id(req_id), .req_data(req_data),
      .req_strb(req_strb),
      .wr_res_valid(wr_res_valid), .wr_res_ready(wr_res_ready),
      .wr_res_id(wr_res_id), .wr_res_err(wr_res_err),
      .rd_res_valid(rd_res_valid), .rd_res_ready(rd_res_ready),
      .rd_res_id(rd_res_id), .rd_res_data(rd_res_data),
      .rd_res_err(rd_res_err),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_wrn(cpl_wrn),
      .cpl_id(cpl_id), .cpl_data(cpl_data), .cpl_err(cpl_err),
      .outstanding_cnt(outstanding_cnt), .protocol_err(protocol_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   bit            m_busy [N];
   bit            m_dir  [N];
   bit            m_req_v, m_req_wrn;
   logic [AW-1:0] m_req_addr;
   logic [IW-1:0] m_req_id;
   logic [DW-1:0] m_req_data;
   logic [SW-1:0] m_req_strb;
   bit            m_cpl_v, m_cpl_wrn, m_cpl_err;
   logic [IW-1:0] m_cpl_id;
   logic [DW-1:0] m_cpl_data;
   bit            m_perr;
   bit            m_rd_turn;

   function automatic int busy_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int pick_id(input bit want_rd);
      int s = $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) begin
         int idx = (s + k) % N;
         if (m_busy[idx] && m_dir[idx] == want_rd) return idx;
      end
      return $urandom_range(0, N - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 0;
         m_dir[i]  = 0;
      end
      m_req_v = 0; m_req_wrn = 0; m_req_addr = '0; m_req_id = '0;
      m_req_data = '0; m_req_strb = '0;
      m_cpl_v = 0; m_cpl_wrn = 0; m_cpl_err = 0; m_cpl_id = '0;
      m_cpl_data = '0; m_perr = 0; m_rd_turn = 1;
   endtask

   task automatic idle();
      rst = 0; cmd_valid = 0; cmd_wrn = 0; cmd_addr = '0;
      cmd_data = '0; cmd_strb = '0; req_ready = 1;
      wr_res_valid = 0; wr_res_id = '0; wr_res_err = 0;
      rd_res_valid = 0; rd_res_id = '0; rd_res_data = '0;
      rd_res_err = 0; cpl_ready = 1;
   endtask

   // Inputs are set at a falling edge; this checks the combinational
   // handshakes, advances the model one clock and checks registers.
   task automatic cycle();
      bit e_cr, e_rr, e_wr, space, rd_acc, wr_acc, ok, r_wrn;
      int a, id;
      #1;
      space = !m_cpl_v || cpl_ready;
      e_cr  = !rst && busy_cnt() < N && (!m_req_v || req_ready);
      e_rr  = !rst && rd_res_valid && (!wr_res_valid || m_rd_turn) && space;
      e_wr  = !rst && wr_res_valid && (!rd_res_valid || !m_rd_turn) && space;
      chk("cmd_ready", cmd_ready, e_cr);
      chk("rd_res_ready", rd_res_ready, e_rr);
      chk("wr_res_ready", wr_res_ready, e_wr);
      if (rst) begin
         model_reset();
      end else begin
         a      = lowest_free();
         rd_acc = rd_res_valid && e_rr;
         wr_acc = wr_res_valid && e_wr;
         if (rd_acc || wr_acc) begin
            r_wrn = rd_acc;
            id    = rd_acc ? int'(rd_res_id) : int'(wr_res_id);
            ok    = m_busy[id] && (m_dir[id] == r_wrn);
            if (rd_res_valid && wr_res_valid) m_rd_turn = !r_wrn;
            m_cpl_v    = 1;
            m_cpl_wrn  = r_wrn;
            m_cpl_id   = IW'(id);
            m_cpl_data = r_wrn ? rd_res_data : '0;
            m_cpl_err  = !ok || (r_wrn ? rd_res_err : wr_res_err);
            if (!ok) m_perr = 1;
            else m_busy[id] = 0;
         end else if (cpl_ready) begin
            m_cpl_v = 0;
         end
         if (cmd_valid && e_cr) begin
            m_busy[a]  = 1;
            m_dir[a]   = cmd_wrn;
            m_req_v    = 1;
            m_req_wrn  = cmd_wrn;
            m_req_addr = cmd_addr;
            m_req_id   = IW'(a);
            m_req_data = cmd_data;
            m_req_strb = cmd_strb;
         end else if (req_ready) begin
            m_req_v = 0;
         end
      end
      @(negedge clk);
      chk("req_valid", req_valid, m_req_v);
      chk("req_wrn", req_wrn, m_req_wrn);
      chk("req_addr", req_addr, m_req_addr);
      chk("req_id", req_id, m_req_id);
      chk("req_data", req_data, m_req_data);
      chk("req_strb", req_strb, m_req_strb);
      chk("cpl_valid", cpl_valid, m_cpl_v);
      chk("cpl_wrn", cpl_wrn, m_cpl_wrn);
      chk("cpl_id", cpl_id, m_cpl_id);
      chk("cpl_data", cpl_data, m_cpl_data);
      chk("cpl_err", cpl_err, m_cpl_err);
      chk("outstanding_cnt", outstanding_cnt, busy_cnt());
      chk("protocol_err", protocol_err, m_perr);
   endtask

   logic [AW-1:0] hold_addr;
   bit            exp_grant [4] = '{1, 0, 1, 0};
   int            rd_ids [4]    = '{0, 1, 1, 2};
   int            wr_ids [4]    = '{3, 3, 4, 4};

   initial begin
      model_reset();
      idle();
      rst = 1;
      cycle();
      cycle();
      chk("rst_req_valid", req_valid, 0);
      chk("rst_cnt", outstanding_cnt, 0);
      rst = 0;

      // Single read round trip
      cmd_valid = 1; cmd_wrn = 1; cmd_addr = 64'h40;
      cycle();
      chk("r046_req_id", req_id, 0);
      chk("r046_req_addr", req_addr, 64'h40);
      cmd_valid = 0;
      cycle();
      rd_res_valid = 1; rd_res_id = 0; rd_res_data = 512'hAB;
      cycle();
      chk("r046_cpl_wrn", cpl_wrn, 1);
      chk("r046_cpl_data", cpl_data, 512'hAB);
      chk("r046_cpl_err", cpl_err, 0);
      rd_res_valid = 0;
      cycle();
      chk("r046_cnt", outstanding_cnt, 0);

      // Contended responses alternate, read first
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1; cmd_wrn = (i < 3); cmd_addr = AW'(i * 64);
         cycle();
      end
      cmd_valid = 0;
      for (int k = 0; k < 4; k++) begin
         rd_res_valid = 1; rd_res_id = IW'(rd_ids[k]);
         rd_res_data = rnd_data();
         wr_res_valid = 1; wr_res_id = IW'(wr_ids[k]);
         cycle();
         chk("r048_grant", cpl_wrn, exp_grant[k]);
      end
      wr_res_valid = 0; rd_res_id = 2;
      cycle();
      rd_res_valid = 0; wr_res_valid = 1; wr_res_id = 5;
      cycle();
      wr_res_valid = 0;
      cycle();
      chk("r048_cnt", outstanding_cnt, 0);

      // Fill the tracker, then reuse a freed ID
      for (int i = 0; i < N; i++) begin
         cmd_valid = 1; cmd_wrn = 0; cmd_data = rnd_data();
         cmd_strb = {$urandom, $urandom};
         cycle();
         chk("r047_id", req_id, i);
      end
      cycle();
      chk("r047_full_ready", cmd_ready, 0);
      chk("r047_full_cnt", outstanding_cnt, 8);
      wr_res_valid = 1; wr_res_id = 3;
      cycle();
      wr_res_valid = 0;
      cycle();
      chk("r047_reuse_id", req_id, 3);
      cmd_valid = 0;
      for (int i = 0; i < N; i++) begin
         wr_res_valid = 1; wr_res_id = IW'(i);
         cycle();
      end
      wr_res_valid = 0;
      cycle();

      // Response to a free ID is a protocol violation
      rd_res_valid = 1; rd_res_id = 5; rd_res_data = rnd_data();
      cycle();
      chk("r049_cpl_err", cpl_err, 1);
      chk("r049_perr", protocol_err, 1);
      chk("r049_cnt", outstanding_cnt, 0);
      rd_res_valid = 0;
      cycle();
      cycle();
      chk("r049_sticky", protocol_err, 1);

      // Stall on req_ready, then reset mid-stall
      req_ready = 0; cmd_valid = 1; cmd_wrn = 1;
      cmd_addr = {$urandom, $urandom};
      hold_addr = cmd_addr;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cmd_addr = {$urandom, $urandom};
         cycle();
         chk("r050_stable", req_addr, hold_addr);
         chk("r050_ready", cmd_ready, 0);
      end
      rst = 1;
      cycle();
      chk("r050_req_valid", req_valid, 0);
      chk("r050_cpl_valid", cpl_valid, 0);
      chk("r050_perr", protocol_err, 0);
      chk("r050_cnt", outstanding_cnt, 0);
      chk("r050_cmd_ready", cmd_ready, 0);
      chk("r050_req_addr", req_addr, 0);
      idle();
      cycle();

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         rst          = ($urandom_range(0, 499) == 0);
         cmd_valid    = $urandom_range(0, 1);
         cmd_wrn      = $urandom_range(0, 1);
         cmd_addr     = {$urandom, $urandom};
         cmd_data     = rnd_data();
         cmd_strb     = {$urandom, $urandom};
         req_ready    = ($urandom_range(0, 9) < 7);
         rd_res_valid = ($urandom_range(0, 9) < 4);
         rd_res_id    = IW'(($urandom_range(0, 15) == 0) ?
                            $urandom_range(0, N - 1) : pick_id(1));
         rd_res_data  = rnd_data();
         rd_res_err   = ($urandom_range(0, 7) == 0);
         wr_res_valid = ($urandom_range(0, 9) < 4);
         wr_res_id    = IW'(($urandom_range(0, 15) == 0) ?
                            $urandom_range(0, N - 1) : pick_id(0));
         wr_res_err   = ($urandom_range(0, 7) == 0);
         cpl_ready    = ($urandom_range(0, 9) < 7);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_req_initiator.md
MEM_REQ_INITIATOR -- requirements
Module: mem_req_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8: tracker depth, a power of 2 and at least 2; ID_WIDTH = clog2(MAX_OUTSTANDING).
REQ-004 SHALL have port clk, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted.
REQ-008 SHALL have port cmd_wrn, input, 1: 1=read, 0=write.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH: command address.
REQ-010 SHALL have port cmd_data, input, DATA_WIDTH: write data.
REQ-011 SHALL have port cmd_strb, input, DATA_WIDTH/8: write byte strobes.
REQ-012 SHALL have port req_valid, output, 1: memory request valid.
REQ-013 SHALL have port req_ready, input, 1: memory accepts request.
REQ-014 SHALL have port req_wrn, output, 1: request direction.
REQ-015 SHALL have port req_addr, output, ADDR_WIDTH: request address.
REQ-016 SHALL have port req_id, output, ID_WIDTH: allocated transaction ID.
REQ-017 SHALL have port req_data, output, DATA_WIDTH: request data.
REQ-018 SHALL have port req_strb, output, DATA_WIDTH/8: request strobes.
REQ-019 SHALL have port wr_res_valid, input, 1: write response valid.
REQ-020 SHALL have port wr_res_ready, output, 1: write response accepted.
REQ-021 SHALL have port wr_res_id, input, ID_WIDTH: write response ID.
REQ-022 SHALL have port wr_res_err, input, 1: write error.
REQ-023 SHALL have port rd_res_valid, input, 1: read response valid.
REQ-024 SHALL have port rd_res_ready, output, 1: read response accepted.
REQ-025 SHALL have port rd_res_id, input, ID_WIDTH: read response ID.
REQ-026 SHALL have port rd_res_data, input, DATA_WIDTH: read data.
REQ-027 SHALL have port rd_res_err, input, 1: read error.
REQ-028 SHALL have port cpl_valid, output, 1: completion valid.
REQ-029 SHALL have port cpl_ready, input, 1: completion consumed.
REQ-030 SHALL have port cpl_wrn, output, 1: completion direction.
REQ-031 SHALL have port cpl_id, output, ID_WIDTH: completion ID.
REQ-032 SHALL have port cpl_data, output, DATA_WIDTH: read data; 0 for writes.
REQ-033 SHALL have port cpl_err, output, 1: response error or protocol violation.
REQ-034 SHALL have port outstanding_cnt, output, ID_WIDTH+1: number of IDs in use.
REQ-035 SHALL have port protocol_err, output, 1: sticky protocol violation flag.

Function
REQ-036 cmd_ready SHALL be 1 when a free ID exists and (req_valid is 0 or req_ready is 1); an accepted command SHALL appear registered on req_* the next cycle; req_amo is not generated and is tied to 0 at integration.
REQ-037 The allocated ID SHALL be the lowest-index free tracker entry; the entry records valid=1 and wrn at command acceptance.
REQ-038 req_* payload SHALL stay stable while req_valid=1 and req_ready=0; back-to-back requests SHALL be possible on consecutive cycles.
REQ-039 When exactly one response valid is asserted, that response is granted; when both are asserted, the grant SHALL alternate, starting with read after reset.
REQ-040 The granted ready output SHALL equal (cpl_valid==0 or cpl_ready==1), and the non-granted ready output SHALL be 0.
REQ-041 An accepted response SHALL load the completion register the next cycle and free its tracker entry; the freed ID is allocatable from the following cycle, not the same cycle.
REQ-042 A response whose ID is not outstanding, or whose direction mismatches the entry's wrn, SHALL still be accepted with cpl_err=1 and protocol_err set (sticky), and the tracker SHALL be left unchanged.
REQ-043 outstanding_cnt SHALL increment on command accept and decrement on a valid response accept; both in the same cycle SHALL leave it unchanged.
REQ-044 When full (outstanding_cnt==MAX_OUTSTANDING), cmd_ready SHALL be 0.

Reset
REQ-045 While rst=1 at a clk edge: req_valid, cpl_valid, cmd_ready, rd_res_ready, wr_res_ready, protocol_err and outstanding_cnt SHALL be 0; all tracker entries SHALL be freed; payload registers SHALL be 0; an in-flight request or completion SHALL be dropped.

Verification
REQ-046 Read cmd addr 0x40 with req_ready=1, then rd_res id 0, data 0xAB -> req_id 0 on the cycle after accept; cpl_wrn=1, cpl_data=0xAB, cpl_err=0; outstanding_cnt returns to 0.
REQ-047 Eight commands with no responses -> IDs 0..7 issued, outstanding_cnt=8, cmd_ready=0; one write response with id 3 -> the next command receives id 3.
REQ-048 rd_res_valid and wr_res_valid held together for 4 cycles with cpl_ready=1 -> grants go read, write, read, write.
REQ-049 rd_res id 5 while entry 5 is free -> cpl_err=1, protocol_err=1 and remains 1, outstanding_cnt unchanged.
REQ-050 req_ready=0 for 5 cycles with cmd_valid=1 -> req payload stable and cmd_ready=0; rst pulsed mid-stall -> all outputs 0 on the next cycle.
